mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_if.sv | 34 +++
 rtl/mem_access_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// Request/response and data-memory bus of the load/store access controller.
interface mem_access_ctrl_if;
    // Core request channel
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    // Core response channel
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [7:0]  err_count;
    // Data memory port (word indexed, one-cycle read latency)
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // Controller side
    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, err_count,
        output mem_re, mem_we, mem_addr, mem_wdata
    );

    // Core and memory side
    modport master (
        output req_valid, req_op, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, err_count,
        input  mem_re, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// MIPS load/store access controller: validates requests, performs word reads,
// word writes and read-modify-write sub-word stores against a 32-bit memory.
module mem_access_ctrl #(
    parameter int unsigned MEM_DEPTH = 32
) (
    input logic              clk,
    input logic              rst,
    mem_access_ctrl_if.slave bus
);

    localparam logic [5:0] OpLb  = 6'b100000;
    localparam logic [5:0] OpLh  = 6'b100001;
    localparam logic [5:0] OpLw  = 6'b100011;
    localparam logic [5:0] OpLbu = 6'b100100;
    localparam logic [5:0] OpLhu = 6'b100101;
    localparam logic [5:0] OpSb  = 6'b101000;
    localparam logic [5:0] OpSh  = 6'b101001;
    localparam logic [5:0] OpSw  = 6'b101011;

    typedef enum logic [2:0] {StIdle, StRd, StRdw, StWr, StResp} state_e;

    state_e      state_q, state_d;
    logic [5:0]  op_q, op_d;
    logic [1:0]  lane_q, lane_d;
    logic [15:0] wdata_q, wdata_d;   // only the sub-word store data is needed later
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic [7:0]  err_count_q, err_count_d;
    logic        mem_re_q, mem_re_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic [31:0] word_idx;
    logic        accept;
    logic        reject;
    logic        rmw_store;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_val;
    logic [31:0] merged;

    assign word_idx      = {2'b00, bus.req_addr[31:2]};
    assign bus.req_ready = (state_q == StIdle) && rst;
    assign accept        = bus.req_valid && bus.req_ready;
    assign rmw_store     = (op_q == OpSb) || (op_q == OpSh);

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.err_count  = err_count_q;
    assign bus.mem_re     = mem_re_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;

    // Classify the incoming request: unknown opcode, misalignment or out-of-range word.
    always_comb begin
        reject = 1'b0;
        unique case (bus.req_op)
            OpLb, OpLbu, OpSb: reject = 1'b0;
            OpLh, OpLhu, OpSh: reject = bus.req_addr[0];
            OpLw, OpSw:        reject = (bus.req_addr[1:0] != 2'b00);
            default:           reject = 1'b1;
        endcase
        if (word_idx >= MEM_DEPTH) begin
            reject = 1'b1;
        end
    end

    // Little-endian lane extraction and sub-word merge on the returned read word.
    always_comb begin
        unique case (lane_q)
            2'd0:    rd_byte = bus.mem_rdata[7:0];
            2'd1:    rd_byte = bus.mem_rdata[15:8];
            2'd2:    rd_byte = bus.mem_rdata[23:16];
            default: rd_byte = bus.mem_rdata[31:24];
        endcase
        rd_half = lane_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

        unique case (op_q)
            OpLb:    load_val = {{24{rd_byte[7]}}, rd_byte};
            OpLbu:   load_val = {24'd0, rd_byte};
            OpLh:    load_val = {{16{rd_half[15]}}, rd_half};
            OpLhu:   load_val = {16'd0, rd_half};
            default: load_val = bus.mem_rdata;
        endcase

        merged = bus.mem_rdata;
        if (op_q == OpSb) begin
            unique case (lane_q)
                2'd0:    merged[7:0]   = wdata_q[7:0];
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (lane_q[1]) begin
            merged[31:16] = wdata_q;
        end else begin
            merged[15:0] = wdata_q;
        end
    end

    // Next-state and registered-output logic; enables and responses are one-cycle pulses.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        lane_d       = lane_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = resp_rdata_q;
        err_count_d  = err_count_q;
        mem_re_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d    = bus.req_op;
                    lane_d  = bus.req_addr[1:0];
                    wdata_d = bus.req_wdata[15:0];
                    if (reject) begin
                        state_d      = StResp;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'd0;
                        if (err_count_q != 8'hFF) begin
                            err_count_d = err_count_q + 8'd1;
                        end
                    end else if (bus.req_op == OpSw) begin
                        state_d     = StWr;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = word_idx;
                        mem_wdata_d = bus.req_wdata;
                    end else begin
                        // Loads and sub-word stores both start with a read.
                        state_d    = StRd;
                        mem_re_d   = 1'b1;
                        mem_addr_d = word_idx;
                    end
                end
            end
            StRd: begin
                state_d = StRdw;
            end
            StRdw: begin
                if (rmw_store) begin
                    state_d     = StWr;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = merged;
                end else begin
                    state_d      = StResp;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_val;
                end
            end
            StWr: begin
                state_d      = StResp;
                resp_valid_d = 1'b1;
                resp_rdata_d = 32'd0;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with synchronous active-low reset; reset drops any pending write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            op_q         <= 6'd0;
            lane_q       <= 2'd0;
            wdata_q      <= 16'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
            err_count_q  <= 8'd0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            lane_q       <= lane_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            err_count_q  <= err_count_d;
            mem_re_q     <= mem_re_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a 32-word behavioural data memory.
module tb_mem_access_ctrl;

    localparam logic [5:0] OpLb  = 6'b100000;
    localparam logic [5:0] OpLh  = 6'b100001;
    localparam logic [5:0] OpLw  = 6'b100011;
    localparam logic [5:0] OpLbu = 6'b100100;
    localparam logic [5:0] OpLhu = 6'b100101;
    localparam logic [5:0] OpSb  = 6'b101000;
    localparam logic [5:0] OpSh  = 6'b101001;
    localparam logic [5:0] OpSw  = 6'b101011;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_access_ctrl_if bus();

    mem_access_ctrl #(.MEM_DEPTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural memory: one-cycle read latency, plus a bench-side preload port.
    logic [31:0] mem [32];
    logic        pre_we = 1'b0;
    logic [4:0]  pre_idx = 5'd0;
    logic [31:0] pre_data = 32'd0;

    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_data;
        else if (bus.mem_we) mem[bus.mem_addr[4:0]] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr[4:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [4:0] idx, input logic [31:0] data);
        pre_we   = 1'b1;
        pre_idx  = idx;
        pre_data = data;
        tick();
        pre_we   = 1'b0;
    endtask

    // Presents a request in cycle 0 and returns in cycle 1.
    task automatic issue(input string tag, input logic [5:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata);
        check({tag, "_ready"}, bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [5:0] op, input logic [31:0] addr,
                           input logic [31:0] exp);
        issue(tag, op, addr, 32'h0);
        check({tag, "_re_c1"}, bus.mem_re, 1);
        check({tag, "_addr_c1"}, bus.mem_addr, {2'b00, addr[31:2]});
        check({tag, "_we_c1"}, bus.mem_we, 0);
        tick();
        check({tag, "_re_c2"}, bus.mem_re, 0);
        check({tag, "_rv_c2"}, bus.resp_valid, 0);
        tick();
        check({tag, "_rv_c3"}, bus.resp_valid, 1);
        check({tag, "_rdata"}, bus.resp_rdata, exp);
        check({tag, "_err"}, bus.resp_err, 0);
        tick();
        check({tag, "_rv_c4"}, bus.resp_valid, 0);
        check({tag, "_hold"}, bus.resp_rdata, exp);
    endtask

    task automatic do_sw(input string tag, input logic [31:0] addr, input logic [31:0] wdata);
        issue(tag, OpSw, addr, wdata);
        check({tag, "_we_c1"}, bus.mem_we, 1);
        check({tag, "_re_c1"}, bus.mem_re, 0);
        check({tag, "_wdata_c1"}, bus.mem_wdata, wdata);
        tick();
        check({tag, "_we_c2"}, bus.mem_we, 0);
        check({tag, "_rv_c2"}, bus.resp_valid, 1);
        check({tag, "_rdata_c2"}, bus.resp_rdata, 0);
        check({tag, "_err_c2"}, bus.resp_err, 0);
        tick();
    endtask

    task automatic do_rmw(input string tag, input logic [5:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_word);
        issue(tag, op, addr, wdata);
        check({tag, "_re_c1"}, bus.mem_re, 1);
        tick();
        check({tag, "_en_c2"}, {bus.mem_re, bus.mem_we}, 0);
        tick();
        check({tag, "_we_c3"}, bus.mem_we, 1);
        check({tag, "_re_c3"}, bus.mem_re, 0);
        check({tag, "_wdata_c3"}, bus.mem_wdata, exp_word);
        check({tag, "_addr_c3"}, bus.mem_addr, {2'b00, addr[31:2]});
        check({tag, "_rv_c3"}, bus.resp_valid, 0);
        tick();
        check({tag, "_we_c4"}, bus.mem_we, 0);
        check({tag, "_rv_c4"}, bus.resp_valid, 1);
        check({tag, "_rdata_c4"}, bus.resp_rdata, 0);
        tick();
    endtask

    task automatic do_err(input string tag, input logic [5:0] op, input logic [31:0] addr);
        issue(tag, op, addr, 32'hFFFF_FFFF);
        check({tag, "_rv_c1"}, bus.resp_valid, 1);
        check({tag, "_err_c1"}, bus.resp_err, 1);
        check({tag, "_rdata_c1"}, bus.resp_rdata, 0);
        check({tag, "_en_c1"}, {bus.mem_re, bus.mem_we}, 0);
        tick();
        check({tag, "_rv_c2"}, bus.resp_valid, 0);
        check({tag, "_en_c2"}, {bus.mem_re, bus.mem_we}, 0);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = 6'd0;
        bus.req_addr  = 32'd0;
        bus.req_wdata = 32'd0;

        // Reset state
        tick();
        tick();
        check("rst_ready", bus.req_ready, 0);
        check("rst_rv", bus.resp_valid, 0);
        check("rst_err", bus.resp_err, 0);
        check("rst_rdata", bus.resp_rdata, 0);
        check("rst_errcnt", bus.err_count, 0);
        check("rst_en", {bus.mem_re, bus.mem_we}, 0);
        check("rst_maddr", bus.mem_addr, 0);
        check("rst_mwdata", bus.mem_wdata, 0);
        preload(5'd0, 32'h0102_0304);
        preload(5'd2, 32'hAABB_CCDD);
        preload(5'd3, 32'h1122_3344);
        preload(5'd31, 32'hCAFE_F00D);
        rst = 1'b1;
        tick();
        check("post_rst_ready", bus.req_ready, 1);

        // Word and sub-word loads, sign/zero extension
        do_load("lw_0c", OpLw, 32'h0C, 32'h1122_3344);
        do_load("lb_0f", OpLb, 32'h0F, 32'h0000_0011);
        do_sw("sw_0c", 32'h0C, 32'h80FF_0000);
        do_load("lh_0e", OpLh, 32'h0E, 32'hFFFF_80FF);
        do_load("lhu_0e", OpLhu, 32'h0E, 32'h0000_80FF);
        do_load("lb_0d", OpLb, 32'h0D, 32'h0000_0000);
        do_load("lbu_0e", OpLbu, 32'h0E, 32'h0000_00FF);
        do_load("lb_0e", OpLb, 32'h0E, 32'hFFFF_FFFF);

        // Read-modify-write stores
        do_rmw("sb_09", OpSb, 32'h09, 32'h1234_5677, 32'hAABB_77DD);
        do_load("lw_08a", OpLw, 32'h08, 32'hAABB_77DD);
        do_rmw("sh_0a", OpSh, 32'h0A, 32'h0000_BEEF, 32'hBEEF_77DD);
        do_load("lw_08b", OpLw, 32'h08, 32'hBEEF_77DD);

        // Last legal word
        do_load("lw_7c", OpLw, 32'h7C, 32'hCAFE_F00D);

        // Rejections
        do_err("err_lw02", OpLw, 32'h02);
        do_err("err_sh01", OpSh, 32'h01);
        do_err("err_sw80", OpSw, 32'h80);
        check("errcnt_3", bus.err_count, 3);

        // Saturation of the rejection counter
        do_err("err_op0", 6'b000000, 32'h0);
        check("errcnt_4", bus.err_count, 4);
        for (int i = 0; i < 299; i++) begin
            bus.req_valid = 1'b1;
            bus.req_op    = 6'b000000;
            bus.req_addr  = 32'h0;
            tick();
            bus.req_valid = 1'b0;
            tick();
        end
        check("errcnt_sat", bus.err_count, 255);
        do_load("lw_00", OpLw, 32'h00, 32'h0102_0304);
        check("errcnt_hold", bus.err_count, 255);

        // Reset sampled in RDW of a sub-word store drops the write
        issue("sh_rst", OpSh, 32'h0A, 32'h0000_1234);
        check("sh_rst_re_c1", bus.mem_re, 1);
        tick();
        rst = 1'b0;
        tick();
        check("sh_rst_we", bus.mem_we, 0);
        check("sh_rst_rv", bus.resp_valid, 0);
        check("sh_rst_ready0", bus.req_ready, 0);
        check("sh_rst_errcnt", bus.err_count, 0);
        rst = 1'b1;
        tick();
        check("sh_rst_ready1", bus.req_ready, 1);
        check("sh_rst_we2", bus.mem_we, 0);
        check("sh_rst_rv2", bus.resp_valid, 0);
        do_load("lw_08c", OpLw, 32'h08, 32'hBEEF_77DD);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
